// File: rtl/gauss_window_gen.sv
// Streaming KSIZE x KSIZE zero-padded window generator for the Gaussian convolution stage.
// Line buffers plus a shift window build each window; boundary taps are masked at the output register.
module gauss_window_gen #(
  parameter int ROWS  = 168,
  parameter int COLS  = 220,
  parameter int KSIZE = 5,
  parameter int DW    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_pixel,
  input  logic                        in_sof,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [KSIZE*KSIZE*DW-1:0]   out_window,
  output logic [$clog2(ROWS)-1:0]     out_row,
  output logic [$clog2(COLS)-1:0]     out_col,
  output logic                        out_sof,
  output logic                        out_eof
);

  localparam int H     = KSIZE / 2;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int NPIX  = ROWS * COLS;
  localparam int NSTEP = NPIX + H * COLS + H;
  localparam int VW    = $clog2(NSTEP + 1);
  localparam logic [VW-1:0] V_LASTPIX  = VW'(NPIX - 1);
  localparam logic [VW-1:0] V_FIRSTWIN = VW'(H * COLS + H);
  localparam logic [VW-1:0] V_LASTSTEP = VW'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_en;
  logic                      r_flush_done;
  logic [VW-1:0]             r_vcnt;
  logic [CW-1:0]             r_wcol;
  logic [RW-1:0]             r_cr;
  logic [CW-1:0]             r_cc;
  logic                      w_adv;
  logic                      w_step;
  logic                      w_restart;
  logic                      w_clear;
  logic                      w_win_done;
  logic [CW-1:0]             w_col;
  logic [DW-1:0]             w_pix;
  logic [DW-1:0]             r_lb      [KSIZE-1][COLS];
  logic [DW-1:0]             r_win     [KSIZE][KSIZE];
  logic [DW-1:0]             w_win_nxt [KSIZE][KSIZE];
  logic [KSIZE*KSIZE*DW-1:0] w_masked;

  always_comb begin
    w_adv       = !out_valid || out_ready;
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_step      = 1'b0;
    w_restart   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready  = r_en && w_adv;
        w_step    = in_ready && in_valid;
        w_restart = w_step;
        if (w_step) w_state_nxt = RUN;
      end
      RUN: begin
        in_ready  = r_en && w_adv;
        w_step    = in_ready && in_valid;
        w_restart = w_step && in_sof;
        if (w_step && !in_sof && r_vcnt == V_LASTPIX) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        // Zeros are injected until the last window is built, then wait for its hand-off.
        w_step = w_adv && !r_flush_done;
        if (out_valid && out_eof && out_ready) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_col      = w_restart ? '0 : r_wcol;
    w_pix      = (r_state == FLUSH) ? '0 : in_pixel;
    w_win_done = w_step && !w_restart && (r_vcnt >= V_FIRSTWIN);
  end

  always_comb begin
    for (int k = 0; k < KSIZE; k++) begin
      for (int l = 0; l < KSIZE - 1; l++) begin
        w_win_nxt[k][l] = r_win[k][l+1];
      end
    end
    // Newest column: live pixel at the bottom, older lines above it from the line buffers.
    w_win_nxt[KSIZE-1][KSIZE-1] = w_pix;
    for (int k = 0; k < KSIZE - 1; k++) begin
      w_win_nxt[k][KSIZE-1] = r_lb[KSIZE-2-k][w_col];
    end
  end

  always_comb begin
    w_masked = '0;
    for (int k = 0; k < KSIZE; k++) begin
      for (int l = 0; l < KSIZE; l++) begin
        if ((int'(r_cr) + k - H) >= 0 && (int'(r_cr) + k - H) < ROWS &&
            (int'(r_cc) + l - H) >= 0 && (int'(r_cc) + l - H) < COLS) begin
          w_masked[(k*KSIZE+l)*DW +: DW] = w_win_nxt[k][l];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_en         <= 1'b0;
      r_flush_done <= 1'b0;
      r_vcnt       <= '0;
      r_wcol       <= '0;
      r_cr         <= '0;
      r_cc         <= '0;
      out_valid    <= 1'b0;
      out_window   <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= 1'b1;
      if (w_step) begin
        r_vcnt <= w_restart ? VW'(1) : r_vcnt + 1'b1;
        r_wcol <= (w_col == CW'(COLS - 1)) ? '0 : w_col + 1'b1;
        if (!w_restart && r_vcnt == V_LASTSTEP) r_flush_done <= 1'b1;
      end
      if (w_restart) begin
        r_cr         <= '0;
        r_cc         <= '0;
        r_flush_done <= 1'b0;
      end else if (w_win_done) begin
        if (r_cc == CW'(COLS - 1)) begin
          r_cc <= '0;
          r_cr <= (r_cr == RW'(ROWS - 1)) ? '0 : r_cr + 1'b1;
        end else begin
          r_cc <= r_cc + 1'b1;
        end
      end
      if (w_clear) begin
        r_vcnt       <= '0;
        r_wcol       <= '0;
        r_cr         <= '0;
        r_cc         <= '0;
        r_flush_done <= 1'b0;
      end
      // Output register: a completed window replaces the held one only when the consumer frees it.
      if (w_adv) begin
        out_valid <= w_win_done;
        if (w_win_done) begin
          out_window <= w_masked;
          out_row    <= r_cr;
          out_col    <= r_cc;
          out_sof    <= (r_cr == '0) && (r_cc == '0);
          out_eof    <= (r_cr == RW'(ROWS - 1)) && (r_cc == CW'(COLS - 1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_step) begin
      for (int k = 0; k < KSIZE; k++) begin
        for (int l = 0; l < KSIZE; l++) begin
          r_win[k][l] <= w_win_nxt[k][l];
        end
      end
      r_lb[0][w_col] <= w_pix;
      for (int j = 1; j < KSIZE - 1; j++) begin
        r_lb[j][w_col] <= r_lb[j-1][w_col];
      end
    end
  end

endmodule
